// File: rtl/bootrom_arb.sv
// Two-port arbiter and strobe sequencer for the 8x16 boot ROM (M0 = CPU read, M1 = host read/write).
// Define BOOTROM_ARB_RR_EN for round-robin arbitration; otherwise M1 has fixed priority over M0.
module bootrom_arb #(
  parameter int          DW    = 16,
  parameter int          AW    = 3,
  parameter int unsigned WADDR = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic          m1_err,
  output logic [DW-1:0] m1_rdata,
  output logic          rom_cs,
  output logic          rom_we,
  output logic [AW-1:0] rom_addr,
  output logic [DW-1:0] rom_din,
  input  logic [DW-1:0] rom_dout
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t        state_q, state_d;
  logic          sel_q, sel_d;
  logic          wr_q, wr_d;
  logic          m0_ack_q, m0_ack_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic          m1_ack_q, m1_ack_d;
  logic          m1_err_q, m1_err_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;
  logic          rom_cs_q, rom_cs_d;
  logic          rom_we_q, rom_we_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic [DW-1:0] rom_din_q, rom_din_d;
  logic          grant;
  logic          wr_err;

`ifdef BOOTROM_ARB_RR_EN
  logic ptr_q, ptr_d;

  // Pointer names the preferred port; it moves to the other port after every ack.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == RESP) ptr_d = ~sel_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

  assign grant = (m0_req && m1_req) ? ptr_q : m1_req;
`else
  assign grant = m1_req;
`endif

  // Writes outside the boot-vector word are refused without touching the ROM.
  assign wr_err = grant && m1_we && (m1_addr != AW'(WADDR));

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    wr_d       = wr_q;
    m0_ack_d   = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_ack_d   = 1'b0;
    m1_err_d   = 1'b0;
    m1_rdata_d = m1_rdata_q;
    rom_cs_d   = 1'b0;
    rom_we_d   = 1'b0;
    rom_addr_d = rom_addr_q;
    rom_din_d  = rom_din_q;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          sel_d = grant;
          if (wr_err) begin
            wr_d     = 1'b1;
            m1_ack_d = 1'b1;
            m1_err_d = 1'b1;
            state_d  = RESP;
          end else begin
            wr_d       = grant && m1_we;
            rom_addr_d = grant ? m1_addr : m0_addr;
            if (grant) rom_din_d = m1_wdata;
            rom_cs_d   = 1'b1;
            state_d    = SETUP;
          end
        end
      end
      SETUP: begin
        // Address and data have been stable for a full cycle before we rises.
        rom_cs_d = 1'b1;
        rom_we_d = wr_q;
        state_d  = ACCESS;
      end
      ACCESS: begin
        if (sel_q) m1_ack_d = 1'b1;
        else       m0_ack_d = 1'b1;
        if (!wr_q) begin
          if (sel_q) m1_rdata_d = rom_dout;
          else       m0_rdata_d = rom_dout;
        end
        state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= 1'b0;
      wr_q       <= 1'b0;
      m0_ack_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_ack_q   <= 1'b0;
      m1_err_q   <= 1'b0;
      m1_rdata_q <= '0;
      rom_cs_q   <= 1'b0;
      rom_we_q   <= 1'b0;
      rom_addr_q <= '0;
      rom_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      wr_q       <= wr_d;
      m0_ack_q   <= m0_ack_d;
      m0_rdata_q <= m0_rdata_d;
      m1_ack_q   <= m1_ack_d;
      m1_err_q   <= m1_err_d;
      m1_rdata_q <= m1_rdata_d;
      rom_cs_q   <= rom_cs_d;
      rom_we_q   <= rom_we_d;
      rom_addr_q <= rom_addr_d;
      rom_din_q  <= rom_din_d;
    end
  end

  assign m0_ack   = m0_ack_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_ack   = m1_ack_q;
  assign m1_err   = m1_err_q;
  assign m1_rdata = m1_rdata_q;
  assign rom_cs   = rom_cs_q;
  assign rom_we   = rom_we_q;
  assign rom_addr = rom_addr_q;
  assign rom_din  = rom_din_q;

endmodule

// File: tb/tb_bootrom_arb.sv
// Bench for bootrom_arb: directed and random transactions against a transaction-level model of the ROM and arbiter.
module tb_bootrom_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_req = 1'b0;
  logic [2:0]  m0_addr = '0;
  logic        m0_ack;
  logic [15:0] m0_rdata;
  logic        m1_req = 1'b0;
  logic        m1_we = 1'b0;
  logic [2:0]  m1_addr = '0;
  logic [15:0] m1_wdata = '0;
  logic        m1_ack;
  logic        m1_err;
  logic [15:0] m1_rdata;
  logic        rom_cs;
  logic        rom_we;
  logic [2:0]  rom_addr;
  logic [15:0] rom_din;
  logic [15:0] rom_dout_r;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int cs_cnt = 0;

  logic [15:0] rom_mem [8];
  logic [15:0] ref_mem [8];
  logic [15:0] exp_rd0, exp_rd1;
  bit          last_served;

  logic        prev_cs, prev_we;
  logic [2:0]  prev_addr;
  logic [15:0] prev_din;

  always #5 clk = ~clk;

  bootrom_arb dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .rom_cs(rom_cs), .rom_we(rom_we), .rom_addr(rom_addr), .rom_din(rom_din),
    .rom_dout(rom_dout_r)
  );

  function automatic logic [15:0] rom_init(input int a);
    case (a)
      0: return 16'hF200;
      1: return 16'hF210;
      2: return 16'hF300;
      3: return 16'hF400;
      4: return 16'hB007;
      5: return 16'h6007;
      6: return 16'hA5A5;
      default: return 16'h0008;
    endcase
  endfunction

  // Boot ROM device: output latched while selected for read, write on cs & we.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rom_mem[i] <= rom_init(i);
      rom_dout_r <= '0;
    end else if (rom_cs) begin
      if (rom_we) rom_mem[rom_addr] <= rom_din;
      else        rom_dout_r <= rom_mem[rom_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_out();
    return {8'h0, m0_ack, m0_rdata, m1_ack, m1_err, m1_rdata, rom_cs, rom_we, rom_addr, rom_din};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      check("ack_overlap", {63'h0, m0_ack & m1_ack}, 64'h0);
      check("err_without_ack", {63'h0, m1_err & ~m1_ack}, 64'h0);
      check("we_without_cs", {63'h0, rom_we & ~rom_cs}, 64'h0);
      if (rom_cs) cs_cnt++;
      if (rom_we) begin
        we_cnt++;
        check("we_setup_stable", {prev_cs, prev_we, prev_addr, prev_din}, {1'b1, 1'b0, rom_addr, rom_din});
      end
      prev_cs   = rom_cs;
      prev_we   = rom_we;
      prev_addr = rom_addr;
      prev_din  = rom_din;
    end
  end

  function automatic bit model_winner();
`ifdef BOOTROM_ARB_RR_EN
    return ~last_served;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) ref_mem[i] = rom_init(i);
    exp_rd0 = '0;
    exp_rd1 = '0;
    last_served = 1'b1;
  endtask

  task automatic wait_ack(output int n, output bit p);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m0_ack || m1_ack) && n < 20);
    p = m1_ack;
  endtask

  // Applies one completed transaction to the model and checks the acked port's results.
  task automatic resolve(input bit p, input bit we, input logic [2:0] a, input logic [15:0] wd);
    bit err;
    err = p && we && (a != 3'd7);
    if (p) check("m1_err", {63'h0, m1_err}, {63'h0, err});
    if (!err && we) ref_mem[a] = wd;
    else if (!err && !we) begin
      if (p) exp_rd1 = ref_mem[a];
      else   exp_rd0 = ref_mem[a];
    end
    check("m0_rdata", {48'h0, m0_rdata}, {48'h0, exp_rd0});
    check("m1_rdata", {48'h0, m1_rdata}, {48'h0, exp_rd1});
    last_served = p;
  endtask

  task automatic single(input bit p, input bit we, input logic [2:0] a, input logic [15:0] wd);
    int n;
    bit ap, err;
    err = p && we && (a != 3'd7);
    @(negedge clk);
    if (p) begin m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = wd; end
    else   begin m0_req = 1'b1; m0_addr = a; end
    we_cnt = 0;
    cs_cnt = 0;
    wait_ack(n, ap);
    m0_req = 1'b0;
    m1_req = 1'b0;
    check("ack_port", {63'h0, ap}, {63'h0, p});
    check("latency", 64'(n), err ? 64'd1 : 64'd3);
    resolve(p, we, a, wd);
    if (p && we) begin
      check("we_cycles", 64'(we_cnt), err ? 64'd0 : 64'd1);
      check("cs_cycles", 64'(cs_cnt), err ? 64'd0 : 64'd2);
    end
  endtask

  task automatic both(input logic [2:0] a0, input bit we1, input logic [2:0] a1, input logic [15:0] wd1);
    int n1, n2;
    bit p1, p2, w, err1, err2;
    w = model_winner();
    err1 = w && we1 && (a1 != 3'd7);
    err2 = !w && we1 && (a1 != 3'd7);
    @(negedge clk);
    m0_req = 1'b1; m0_addr = a0;
    m1_req = 1'b1; m1_we = we1; m1_addr = a1; m1_wdata = wd1;
    wait_ack(n1, p1);
    check("first_port", {63'h0, p1}, {63'h0, w});
    check("first_latency", 64'(n1), err1 ? 64'd1 : 64'd3);
    if (p1) begin m1_req = 1'b0; resolve(1'b1, we1, a1, wd1); end
    else    begin m0_req = 1'b0; resolve(1'b0, 1'b0, a0, 16'h0); end
    wait_ack(n2, p2);
    m0_req = 1'b0;
    m1_req = 1'b0;
    check("second_port", {63'h0, p2}, {63'h0, ~w});
    check("second_latency", 64'(n2), err2 ? 64'd2 : 64'd4);
    if (p2) resolve(1'b1, we1, a1, wd1);
    else    resolve(1'b0, 1'b0, a0, 16'h0);
  endtask

  initial begin
    int          k;
    logic [2:0]  a, a1;
    logic [15:0] d;
    bit          wa, bw;

    model_reset();
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("outputs_during_reset", all_out(), 64'h0);
    rst = 1'b0;
    @(negedge clk);
    check("outputs_after_reset", all_out(), 64'h0);

    single(1'b0, 1'b0, 3'd0, 16'h0);
    check("tp_m0_addr0", {48'h0, m0_rdata}, 64'hF200);
    check("tp_m1_quiet", {46'h0, m1_ack, m1_err, m1_rdata}, 64'h0);

    single(1'b1, 1'b1, 3'd7, 16'h1234);
    single(1'b0, 1'b0, 3'd7, 16'h0);
    check("tp_boot_vector", {48'h0, m0_rdata}, 64'h1234);

    single(1'b1, 1'b1, 3'd3, 16'hBEEF);
    single(1'b0, 1'b0, 3'd3, 16'h0);
    check("tp_addr3_untouched", {48'h0, m0_rdata}, 64'hF400);

    single(1'b1, 1'b0, 3'd6, 16'h0);
    both(3'd4, 1'b0, 3'd5, 16'h0);
    check("tp_contend_m0", {48'h0, m0_rdata}, 64'hB007);
    check("tp_contend_m1", {48'h0, m1_rdata}, 64'h6007);

    // Reset while an M1 write to the boot vector sits in ACCESS.
    @(negedge clk);
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 3'd7; m1_wdata = 16'hDEAD;
    repeat (2) @(negedge clk);
    check("we_in_access", {63'h0, rom_we}, 64'h1);
    #1 rst = 1'b1;
    m1_req = 1'b0;
    #1 check("outputs_reset_mid", all_out(), 64'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    repeat (4) begin
      @(negedge clk);
      check("no_ack_after_reset", {62'h0, m0_ack, m1_ack}, 64'h0);
    end
    single(1'b0, 1'b0, 3'd7, 16'h0);
    check("tp_vector_reloaded", {48'h0, m0_rdata}, 64'h0008);

    for (int i = 0; i < 40; i++) begin
      k  = int'($urandom_range(0, 3));
      a  = 3'($urandom_range(0, 7));
      a1 = 3'($urandom_range(0, 7));
      d  = 16'($urandom);
      wa = 1'($urandom_range(0, 1));
      bw = 1'($urandom_range(0, 1));
      case (k)
        0: single(1'b0, 1'b0, a, 16'h0);
        1: single(1'b1, 1'b0, a, 16'h0);
        2: single(1'b1, 1'b1, wa ? 3'd7 : a, d);
        default: both(a, bw, (bw && wa) ? 3'd7 : a1, d);
      endcase
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
